// File: rtl/siege_video_pkg.sv
// Shared vertical timing constants and mode types for the Siege raster timing generator.
package siege_video_pkg;

    localparam int NTSC_V_ACTIVE     = 240;
    localparam int NTSC_V_SYNC_START = 244;
    localparam int NTSC_V_TOTAL      = 262;
    localparam int PAL_V_ACTIVE      = 288;
    localparam int PAL_V_SYNC_START  = 294;
    localparam int PAL_V_TOTAL       = 312;
    localparam int V_SYNC_LEN        = 3;

    typedef struct packed {
        logic pal;
        logic scandouble;
    } vmode_t;

    typedef struct packed {
        logic [8:0] v_total;
        logic [8:0] v_active;
        logic [8:0] v_sync_start;
    } vtiming_t;

    // Vertical geometry depends only on the line standard; scandoubling does not change it.
    function automatic vtiming_t vtiming_of(input vmode_t m);
        vtiming_t t;
        if (m.pal) begin
            t.v_total      = 9'(PAL_V_TOTAL);
            t.v_active     = 9'(PAL_V_ACTIVE);
            t.v_sync_start = 9'(PAL_V_SYNC_START);
        end else begin
            t.v_total      = 9'(NTSC_V_TOTAL);
            t.v_active     = 9'(NTSC_V_ACTIVE);
            t.v_sync_start = 9'(NTSC_V_SYNC_START);
        end
        return t;
    endfunction

endpackage

// File: rtl/siege_video_timing_ce_div.sv
// Pixel clock-enable divider: counts 0..D-1 with D = CE_DIV or CE_DIV/2, ticking on the terminal count.
module siege_ce_div #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CW = $clog2(CE_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] last;

    always_comb begin
        last   = half_i ? CW'(CE_DIV / 2 - 1) : CW'(CE_DIV - 1);
        tick_o = (cnt_q == last);
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/siege_video_timing.sv
// Raster timing generator: pixel enable, h/v counters, frame-boundary mode latch and registered decodes.
module siege_video_timing
    import siege_video_pkg::*;
#(
    parameter int CE_DIV       = 4,
    parameter int H_ACTIVE     = 320,
    parameter int H_SYNC_START = 336,
    parameter int H_SYNC_LEN   = 32,
    parameter int H_TOTAL      = 400
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       line_odd,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic       frame_start
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] H_SS   = 9'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_START + H_SYNC_LEN);

    vmode_t     mode_q;
    vmode_t     mode_in;
    vtiming_t   vt;
    logic       tick;

    // nh_q/nl_q hold the position of the pixel the next tick will present.
    logic [8:0] nh_q, nh_d;
    logic [9:0] nl_q, nl_d;
    logic [9:0] line_last;
    logic       h_wrap, frame_wrap;

    logic [8:0] v_src;
    logic       odd_src;
    logic       hblank_d, hsync_d, vblank_d, vsync_d, frame_start_d;

    logic       ce_pix_q, frame_start_q, line_odd_q;
    logic       hblank_q, hsync_q, vblank_q, vsync_q;
    logic [8:0] hcount_q, vcount_q;

    siege_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
        .clk    (clk),
        .clear_i(!reset_n),
        .half_i (mode_q.scandouble),
        .tick_o (tick)
    );

    always_comb begin
        mode_in.pal        = pal;
        mode_in.scandouble = scandouble;
        vt                 = vtiming_of(mode_q);
        line_last          = mode_q.scandouble ? ({vt.v_total, 1'b0} - 10'd1)
                                               : ({1'b0, vt.v_total} - 10'd1);
        h_wrap             = (nh_q == H_LAST);
        frame_wrap         = h_wrap && (nl_q == line_last);
        nh_d               = h_wrap ? 9'd0 : nh_q + 9'd1;
        nl_d               = nl_q;
        if (h_wrap) begin
            nl_d = frame_wrap ? 10'd0 : nl_q + 10'd1;
        end
    end

    always_comb begin
        v_src         = mode_q.scandouble ? nl_q[9:1] : nl_q[8:0];
        odd_src       = mode_q.scandouble & nl_q[0];
        hblank_d      = (nh_q >= H_ACT);
        hsync_d       = (nh_q >= H_SS) && ({1'b0, nh_q} < H_SE);
        vblank_d      = (v_src >= vt.v_active);
        vsync_d       = (v_src >= vt.v_sync_start)
                     && ({1'b0, v_src} < ({1'b0, vt.v_sync_start} + 10'(V_SYNC_LEN)));
        frame_start_d = tick && (nh_q == 9'd0) && (nl_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q        <= mode_in;
            nh_q          <= 9'd0;
            nl_q          <= 10'd0;
            ce_pix_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hcount_q      <= 9'd0;
            vcount_q      <= 9'd0;
            line_odd_q    <= 1'b0;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            ce_pix_q      <= tick;
            frame_start_q <= frame_start_d;
            if (tick) begin
                hcount_q   <= nh_q;
                vcount_q   <= v_src;
                line_odd_q <= odd_src;
                hblank_q   <= hblank_d;
                hsync_q    <= hsync_d;
                vblank_q   <= vblank_d;
                vsync_q    <= vsync_d;
                nh_q       <= nh_d;
                nl_q       <= nl_d;
                // New mode governs the frame that begins with the next presented pixel.
                if (frame_wrap) begin
                    mode_q <= mode_in;
                end
            end
        end
    end

    assign ce_pix      = ce_pix_q;
    assign frame_start = frame_start_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign line_odd    = line_odd_q;
    assign HBlank      = hblank_q;
    assign HSync       = hsync_q;
    assign VBlank      = vblank_q;
    assign VSync       = vsync_q;

endmodule

// File: tb/tb_siege_video_timing.sv
// Directed bench for siege_video_timing using a shortened line so whole frames fit in the run.
module tb_siege_video_timing;

    localparam int CE_DIV       = 4;
    localparam int H_ACTIVE     = 6;
    localparam int H_SYNC_START = 7;
    localparam int H_SYNC_LEN   = 2;
    localparam int H_TOTAL      = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pal = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       line_odd;
    logic       HBlank, HSync, VBlank, VSync;
    logic       frame_start;

    siege_video_timing #(
        .CE_DIV      (CE_DIV),
        .H_ACTIVE    (H_ACTIVE),
        .H_SYNC_START(H_SYNC_START),
        .H_SYNC_LEN  (H_SYNC_LEN),
        .H_TOTAL     (H_TOTAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pal        (pal),
        .scandouble (scandouble),
        .ce_pix     (ce_pix),
        .hcount     (hcount),
        .vcount     (vcount),
        .line_odd   (line_odd),
        .HBlank     (HBlank),
        .HSync      (HSync),
        .VBlank     (VBlank),
        .VSync      (VSync),
        .frame_start(frame_start)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];

    int d_exp     = 4;
    int last_ce   = -1;
    int space_err = 0;
    int fs_err    = 0;

    always @(negedge clk) begin
        if (ce_pix === 1'b1) begin
            if (last_ce >= 0 && (cyc - last_ce) < d_exp) space_err++;
            last_ce = cyc;
        end
        if (frame_start === 1'b1 && ce_pix !== 1'b1) fs_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ce_pix === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ce_timeout", 0, 1);
    endtask

    task automatic do_reset(input logic p, input logic s, input int d);
        int rel;
        bit ok;
        @(negedge clk);
        pal = p;
        scandouble = s;
        reset_n = 1'b0;
        d_exp = d;
        @(negedge clk);
        check("reset_outputs", {ce_pix, frame_start, hcount, vcount, line_odd,
                                HBlank, HSync, VBlank, VSync}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        wait_ce(ok);
        check("first_ce_latency", cyc - rel, d);
        check("first_pixel", {frame_start, hcount, vcount, line_odd}, {1'b1, 18'd0, 1'b0});
    endtask

    // Walk one frame from the current pixel to the next frame_start, gathering line statistics.
    task automatic scan_frame(input bit sd, input int toggle_v, input int start_c, input int idx0,
                              output int period, output int nlines, output int vs_first,
                              output int vs_lines, output int vb_first, output int seq_err);
        int prev_ce, prev_line, idx, d, exp_v, exp_odd;
        bit done;
        d = sd ? 2 : 4;
        prev_ce = cyc;
        prev_line = cyc;
        idx = idx0;
        period = -1;
        vs_first = -1;
        vb_first = -1;
        vs_lines = 0;
        seq_err = 0;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (ce_pix === 1'b1) begin
                if (cyc - prev_ce != d) seq_err++;
                prev_ce = cyc;
                if (frame_start === 1'b1) begin
                    period = cyc - start_c;
                    done = 1'b1;
                end else if (hcount == 9'd0) begin
                    idx++;
                    if (cyc - prev_line != H_TOTAL * d) seq_err++;
                    prev_line = cyc;
                    exp_v = sd ? (idx >> 1) : idx;
                    exp_odd = sd ? (idx & 1) : 0;
                    if (int'(vcount) != exp_v || int'(line_odd) != exp_odd) seq_err++;
                    if (VSync === 1'b1) begin
                        if (vs_first < 0) vs_first = int'(vcount);
                        vs_lines++;
                    end
                    if (VBlank === 1'b1 && vb_first < 0) vb_first = int'(vcount);
                    if (int'(vcount) == toggle_v) pal = 1'b1;
                end
            end
        end
        nlines = idx + 1;
        if (!done) check("frame_timeout", 0, 1);
    endtask

    initial begin
        int fs0, period, nlines, vs_first, vs_lines, vb_first, seq_err, rel;
        logic [10:0] e;
        bit ok, found;

        // NTSC from reset release
        do_reset(1'b0, 1'b0, 4);
        fs0 = cyc;
        for (int p = 1; p < H_TOTAL; p++) begin
            exp_q.push_back({p >= H_ACTIVE, (p >= H_SYNC_START) && (p < H_SYNC_START + H_SYNC_LEN), 9'(p)});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_ce(ok);
            check("line0_pixel", {HBlank, HSync, hcount}, e);
        end
        wait_ce(ok);
        check("line_period", cyc - fs0, 40);
        check("line1_start", {hcount, vcount, frame_start}, {9'd0, 9'd1, 1'b0});
        scan_frame(1'b0, -1, fs0, 1, period, nlines, vs_first, vs_lines, vb_first, seq_err);
        check("ntsc_frame_period", period, 10480);
        check("ntsc_lines", nlines, 262);
        check("ntsc_vsync_first", vs_first, 244);
        check("ntsc_vsync_lines", vs_lines, 3);
        check("ntsc_vblank_first", vb_first, 240);
        check("ntsc_sequence", seq_err, 0);

        // Scandoubled NTSC
        do_reset(1'b0, 1'b1, 2);
        scan_frame(1'b1, -1, cyc, 0, period, nlines, vs_first, vs_lines, vb_first, seq_err);
        check("sd_frame_period", period, 10480);
        check("sd_lines", nlines, 524);
        check("sd_vsync_first", vs_first, 244);
        check("sd_vsync_lines", vs_lines, 6);
        check("sd_vblank_first", vb_first, 240);
        check("sd_sequence", seq_err, 0);

        // pal raised at vcount 100: current frame stays NTSC, next frame is PAL
        do_reset(1'b0, 1'b0, 4);
        scan_frame(1'b0, 100, cyc, 0, period, nlines, vs_first, vs_lines, vb_first, seq_err);
        check("mid_ntsc_period", period, 10480);
        check("mid_ntsc_lines", nlines, 262);
        check("mid_ntsc_sequence", seq_err, 0);
        scan_frame(1'b0, -1, cyc, 0, period, nlines, vs_first, vs_lines, vb_first, seq_err);
        check("pal_frame_period", period, 12480);
        check("pal_lines", nlines, 312);
        check("pal_vblank_first", vb_first, 288);
        check("pal_vsync_first", vs_first, 294);
        check("pal_vsync_lines", vs_lines, 3);
        check("pal_sequence", seq_err, 0);

        // Reset in the middle of a line, one edge before the next ce_pix would rise
        do_reset(1'b0, 1'b0, 4);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (ce_pix === 1'b1 && vcount == 9'd50 && hcount == 9'd7) found = 1'b1;
        end
        check("midline_target_found", found, 1);
        check("midline_pre_flags", {HBlank, HSync}, 2'b11);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midline_reset", {ce_pix, frame_start, hcount, vcount, line_odd,
                                HBlank, HSync, VBlank, VSync}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        wait_ce(ok);
        check("midline_restart_latency", cyc - rel, 4);
        check("midline_restart_pixel", {frame_start, hcount, vcount}, {1'b1, 18'd0});

        check("ce_spacing", space_err, 0);
        check("fs_without_ce", fs_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
